// File: rtl/potts_pkg.sv
// Shared types and helpers for the Potts sweep controller.
package potts_pkg;

  localparam int SWEEP_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_SNAP,
    S_DONE
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/potts_state_bank.sv
// Replica spin registers: one bit-write port, two whole-replica read ports.
module potts_state_bank
  import potts_pkg::*;
#(
  parameter int NUM_NODES    = 4,
  parameter int COLOR_BITS   = 2,
  parameter int NUM_REPLICAS = 2,
  localparam int SW = NUM_NODES * COLOR_BITS,
  localparam int RW = clog2(NUM_REPLICAS),
  localparam int IW = clog2(SW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] wr_rep,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_bit,
  input  logic [RW-1:0] cur_rep,
  output logic [SW-1:0] cur_state,
  input  logic [RW-1:0] snap_rep,
  output logic [SW-1:0] snap_data
);

  logic [SW-1:0] regs_q [NUM_REPLICAS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REPLICAS; r++)
        regs_q[r] <= '0;
    end else if (we) begin
      regs_q[wr_rep][wr_idx] <= wr_bit;
    end
  end

  assign cur_state = regs_q[cur_rep];
  assign snap_data = regs_q[snap_rep];

endmodule

// File: rtl/potts_sweep_ctrl.sv
// Potts-model Gibbs sweep sequencer over several replica chains.
// Define POTTS_ENERGY_TRACK_EN to add the per-sweep snap_energy sum.
module potts_sweep_ctrl
  import potts_pkg::*;
#(
  parameter int NUM_NODES    = 4,
  parameter int COLOR_BITS   = 2,
  parameter int NUM_REPLICAS = 2,
  parameter int E_WIDTH      = 8,
  parameter int URAM_AWIDTH  = 12,
  localparam int SW = NUM_NODES * COLOR_BITS,
  localparam int BW = clog2(COLOR_BITS),
  localparam int RW = clog2(NUM_REPLICAS),
  localparam int NW = clog2(NUM_NODES),
  localparam int IW = clog2(SW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SWEEP_W-1:0]     num_sweeps,
  output logic                   mem_req,
  output logic [URAM_AWIDTH-1:0] mem_addr,
  output logic [BW-1:0]          bit_idx,
  output logic [RW-1:0]          rep_idx,
  output logic [SW-1:0]          cur_state,
  input  logic                   upd_valid,
  input  logic                   upd_bit,
  input  logic [E_WIDTH-1:0]     upd_delta,
  output logic                   snap_valid,
  input  logic                   snap_ready,
  output logic [SW-1:0]          snap_data,
  output logic [RW-1:0]          snap_rep,
  output logic [SWEEP_W-1:0]     snap_sweep,
  output logic                   busy,
  output logic                   done
`ifdef POTTS_ENERGY_TRACK_EN
  ,
  output logic signed [E_WIDTH+clog2(SW):0] snap_energy
`endif
);

  state_t state_q, state_d;

  logic [BW-1:0]      bit_q;
  logic [NW-1:0]      node_q;
  logic [RW-1:0]      rep_q;
  logic [SWEEP_W-1:0] sweep_q;
  logic [SWEEP_W-1:0] nsw_q;
  logic               ubit_q;
  logic               we;
  logic [IW-1:0]      wr_idx;
  logic               last_bit;
  logic               last_node;
  logic               last_rep;
  logic               last_sweep;
  logic               hs;

  assign last_bit   = bit_q == BW'(COLOR_BITS - 1);
  assign last_node  = node_q == NW'(NUM_NODES - 1);
  assign last_rep   = rep_q == RW'(NUM_REPLICAS - 1);
  assign last_sweep = sweep_q == nsw_q - SWEEP_W'(1);
  assign hs         = snap_valid && snap_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    snap_valid = 1'b0;
    done       = 1'b0;
    we         = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (num_sweeps == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        mem_req = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:
        if (upd_valid) state_d = S_COMMIT;
      S_COMMIT: begin
        we      = 1'b1;
        state_d = (last_bit && last_node) ? S_SNAP : S_ISSUE;
      end
      S_SNAP: begin
        snap_valid = 1'b1;
        if (snap_ready)
          state_d = (last_rep && last_sweep) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q   <= '0;
      node_q  <= '0;
      rep_q   <= '0;
      sweep_q <= '0;
      nsw_q   <= '0;
      ubit_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        nsw_q   <= num_sweeps;
        bit_q   <= '0;
        node_q  <= '0;
        rep_q   <= '0;
        sweep_q <= '0;
      end
      if (state_q == S_WAIT && upd_valid)
        ubit_q <= upd_bit;
      // Node advances only when the colour bit wraps.
      if (we) begin
        if (last_bit) begin
          bit_q  <= '0;
          node_q <= last_node ? '0 : node_q + NW'(1);
        end else begin
          bit_q <= bit_q + BW'(1);
        end
      end
      if (hs) begin
        rep_q <= last_rep ? '0 : rep_q + RW'(1);
        if (last_rep) sweep_q <= sweep_q + SWEEP_W'(1);
      end
    end
  end

  assign wr_idx     = IW'(int'(node_q) * COLOR_BITS + int'(bit_q));
  assign busy       = state_q != S_IDLE;
  assign mem_addr   = URAM_AWIDTH'(node_q);
  assign bit_idx    = bit_q;
  assign rep_idx    = rep_q;
  assign snap_rep   = rep_q;
  assign snap_sweep = sweep_q;

`ifdef POTTS_ENERGY_TRACK_EN
  localparam int EAW = E_WIDTH + clog2(SW) + 1;
  logic signed [EAW-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst || hs)
      acc_q <= '0;
    else if (state_q == S_WAIT && upd_valid)
      acc_q <= acc_q + {{(EAW-E_WIDTH){upd_delta[E_WIDTH-1]}}, upd_delta};
  end

  assign snap_energy = acc_q;
`else
  logic unused_delta;
  assign unused_delta = ^upd_delta;
`endif

  potts_state_bank #(
    .NUM_NODES    (NUM_NODES),
    .COLOR_BITS   (COLOR_BITS),
    .NUM_REPLICAS (NUM_REPLICAS)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_rep    (rep_q),
    .wr_idx    (wr_idx),
    .wr_bit    (ubit_q),
    .cur_rep   (rep_q),
    .cur_state (cur_state),
    .snap_rep  (rep_q),
    .snap_data (snap_data)
  );

endmodule

// File: tb/tb_potts_sweep_ctrl.sv
// Scoreboard bench for potts_sweep_ctrl with a bench-side sampler model.
module tb_potts_sweep_ctrl;
  import potts_pkg::*;

  localparam int NN  = 4;
  localparam int CB  = 2;
  localparam int NR  = 2;
  localparam int EW  = 8;
  localparam int AW  = 12;
  localparam int SW  = NN * CB;
  localparam int EAW = EW + clog2(SW) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   num_sweeps;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [0:0]    bit_idx;
  logic [0:0]    rep_idx;
  logic [SW-1:0] cur_state;
  logic          upd_valid;
  logic          upd_bit;
  logic [EW-1:0] upd_delta;
  logic          snap_valid;
  logic          snap_ready = 1'b0;
  logic [SW-1:0] snap_data;
  logic [0:0]    snap_rep;
  logic [15:0]   snap_sweep;
  logic          busy;
  logic          done;
`ifdef POTTS_ENERGY_TRACK_EN
  logic signed [EAW-1:0] snap_energy;
`endif

  potts_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_sweeps (num_sweeps),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .bit_idx    (bit_idx),
    .rep_idx    (rep_idx),
    .cur_state  (cur_state),
    .upd_valid  (upd_valid),
    .upd_bit    (upd_bit),
    .upd_delta  (upd_delta),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .snap_data  (snap_data),
    .snap_rep   (snap_rep),
    .snap_sweep (snap_sweep),
    .busy       (busy),
    .done       (done)
`ifdef POTTS_ENERGY_TRACK_EN
    ,
    .snap_energy(snap_energy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] data;
    int            rep;
    int            sweep;
    int            energy;
  } snap_t;

  snap_t         exp_q[$];
  logic [SW-1:0] ref_st [NR];
  int            n_chk = 0;
  int            n_fail = 0;
  int            mreq_cnt = 0;
  int            ready_mode = 1;
  int            low_cnt = 0;
  bit            held = 0;
  logic [24:0]   held_v;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: drives snap_ready, then scores the snapshot seen this cycle.
  always @(negedge clk) begin
    snap_t e;
    if (mem_req) mreq_cnt++;
    if (ready_mode == 1) snap_ready = 1'b1;
    else if (ready_mode == 0) snap_ready = 1'($urandom_range(0, 1));
    else if (snap_valid && low_cnt < 10) begin
      snap_ready = 1'b0;
      low_cnt++;
    end else snap_ready = snap_valid;
    if (snap_valid) begin
      chk("snap_no_req", {63'd0, mem_req}, 64'd0);
      if (held)
        chk("snap_stable", {39'd0, snap_data, snap_rep, snap_sweep},
            {39'd0, held_v});
      if (snap_ready) begin
        held = 0;
        low_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("snap_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("snap_data", {56'd0, snap_data}, {56'd0, e.data});
          chk("snap_rep", {63'd0, snap_rep}, 64'(e.rep));
          chk("snap_sweep", {48'd0, snap_sweep}, 64'(e.sweep));
`ifdef POTTS_ENERGY_TRACK_EN
          chk("snap_energy", 64'(int'(snap_energy)), 64'(e.energy));
`endif
        end
      end else begin
        held = 1;
        held_v = {snap_data, snap_rep, snap_sweep};
      end
    end else held = 0;
  end

  task automatic run(input int n, input bit ones, input int dly,
                     input bit neg1, input bit spur);
    int base = mreq_cnt;
    int acc = 0;
    int t;
    int d;
    int dv;
    bit v;
    @(negedge clk);
    start = 1'b1;
    num_sweeps = 16'(n);
    @(negedge clk);
    start = 1'b0;
    num_sweeps = 16'($urandom);
    for (int s = 0; s < n; s++)
      for (int r = 0; r < NR; r++)
        for (int nd = 0; nd < NN; nd++)
          for (int b = 0; b < CB; b++) begin
            t = 0;
            while (!mem_req && t < 60) begin
              @(negedge clk);
              t++;
            end
            if (!mem_req) begin
              chk("mem_req_seen", 64'd0, 64'd1);
              return;
            end
            chk("mem_addr", 64'(mem_addr), 64'(nd));
            chk("bit_idx", 64'(bit_idx), 64'(b));
            chk("rep_idx", 64'(rep_idx), 64'(r));
            chk("cur_state", 64'(cur_state), 64'(ref_st[r]));
            d = (dly >= 0) ? dly : int'($urandom_range(0, 3));
            v = ones ? 1'b1 : 1'($urandom_range(0, 1));
            dv = neg1 ? -1 : int'($urandom_range(0, 255)) - 128;
            @(negedge clk);
            repeat (d) begin
              if (spur && $urandom_range(0, 2) == 0) start = 1'b1;
              @(negedge clk);
              start = 1'b0;
            end
            upd_valid = 1'b1;
            upd_bit = v;
            upd_delta = EW'(dv);
            ref_st[r][nd*CB+b] = v;
            acc += dv;
            if (nd == NN - 1 && b == CB - 1) begin
              exp_q.push_back('{ref_st[r], r, s, acc});
              acc = 0;
            end
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
              upd_bit = ~v;
              upd_delta = 8'h55;
            end else upd_valid = 1'b0;
            @(negedge clk);
            upd_valid = 1'b0;
          end
    t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    if (n == 0) chk("zero_done_lat", 64'(t), 64'd0);
    chk("snap_drained", 64'(exp_q.size()), 64'd0);
    chk("mem_req_count", 64'(mreq_cnt - base), 64'(n * NR * SW));
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int base;
    for (int r = 0; r < NR; r++) ref_st[r] = '0;
    rst = 1'b1;
    start = 1'b0;
    num_sweeps = '0;
    upd_valid = 1'b0;
    upd_bit = 1'b0;
    upd_delta = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_snap_valid", {63'd0, snap_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_addr", 64'({mem_addr, bit_idx, rep_idx}), 64'd0);
    chk("rst_state", 64'(cur_state), 64'd0);
    rst = 1'b0;

    ready_mode = 1;
    run(1, 1'b1, 2, 1'b0, 1'b0);
    run(1, 1'b0, -1, 1'b1, 1'b0);
    ready_mode = 2;
    run(2, 1'b0, -1, 1'b0, 1'b0);
    ready_mode = 1;
    run(0, 1'b0, -1, 1'b0, 1'b0);
    ready_mode = 0;
    run(3, 1'b0, -1, 1'b0, 1'b1);
    repeat (3) run(int'($urandom_range(1, 3)), 1'b0, -1, 1'b0, 1'b1);

    ready_mode = 1;
    base = mreq_cnt;
    @(negedge clk);
    start = 1'b1;
    num_sweeps = 16'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b1;
    upd_bit = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int r = 0; r < NR; r++) ref_st[r] = '0;
    exp_q.delete();
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_state", 64'(cur_state), 64'd0);
    chk("rstmid_req", 64'(mreq_cnt - base), 64'd1);
    run(1, 1'b0, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/potts_sweep_ctrl.md
POTTS_SWEEP_CTRL -- requirements
Module: potts_sweep_ctrl

Interface
REQ-001 SHALL have parameter NUM_NODES, default 4: spins per replica.
REQ-002 SHALL have parameter COLOR_BITS, default 2: bits per integer spin.
REQ-003 SHALL have parameter NUM_REPLICAS, default 2: independent chains held in state registers.
REQ-004 SHALL have parameter E_WIDTH, default 8: signed delta-energy width from the sampler.
REQ-005 SHALL have parameter URAM_AWIDTH, default 12: weight address width.
REQ-006 SHALL have port clk, input, 1: clock; reset rst, synchronous, active-high; clock clk.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1: pulse that begins a run; ignored unless idle.
REQ-009 SHALL have port num_sweeps, input, 16: sweeps per run, latched at start.
REQ-010 SHALL have port mem_req, output, 1: one-cycle weight-row fetch strobe.
REQ-011 SHALL have port mem_addr, output, URAM_AWIDTH: current node index.
REQ-012 SHALL have port bit_idx, output, clog2(COLOR_BITS): colour bit under update.
REQ-013 SHALL have port rep_idx, output, clog2(NUM_REPLICAS): replica under update.
REQ-014 SHALL have port cur_state, output, NUM_NODES*COLOR_BITS: state of replica rep_idx.
REQ-015 SHALL have ports upd_valid (input, 1), upd_bit (input, 1) and upd_delta (input, E_WIDTH): sampler result.
REQ-016 SHALL have ports snap_valid (output, 1), snap_ready (input, 1), snap_data (output, NUM_NODES*COLOR_BITS), snap_rep (output, clog2(NUM_REPLICAS)) and snap_sweep (output, 16).
REQ-017 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-018 SHALL implement FSM IDLE->ISSUE->WAIT->COMMIT->(ISSUE | SNAP)->(ISSUE | DONE)->IDLE.
REQ-019 ISSUE SHALL assert mem_req for exactly one cycle; WAIT SHALL hold until upd_valid; only one request outstanding.
REQ-020 COMMIT SHALL write upd_bit to bit node*COLOR_BITS+bit_idx of replica rep_idx, one cycle after upd_valid.
REQ-021 Order SHALL be bit (inner), node, replica, sweep (outer); mem_addr SHALL change only when bit_idx wraps.
REQ-022 After the last bit of the last node of a replica, SNAP SHALL assert snap_valid with stable snap_* until snap_ready; the transfer completes on the valid&&ready cycle.
REQ-023 snap_sweep SHALL equal the zero-based sweep index.
REQ-024 After the last snapshot of the last sweep, done SHALL pulse one cycle in DONE; busy SHALL be high in every state except IDLE.
REQ-025 num_sweeps=0 SHALL pulse done the cycle after start with no mem_req.
REQ-026 upd_valid outside WAIT SHALL be ignored; start while busy SHALL be ignored.
REQ-027 Replica states SHALL persist across runs; only rst clears them.
REQ-028 Minimum latency per bit SHALL be 3 cycles (ISSUE, WAIT with upd_valid, COMMIT).

Reset
REQ-029 rst SHALL force IDLE, clear all counters and replica states to 0, and drive mem_req, snap_valid, busy and done to 0 and mem_addr, bit_idx and rep_idx to 0.
REQ-030 rst mid-run SHALL abandon the outstanding request; any upd_valid arriving later SHALL be ignored.

Configuration
REQ-031 With POTTS_ENERGY_TRACK_EN defined, a signed accumulator of width E_WIDTH+clog2(NUM_NODES*COLOR_BITS)+1 SHALL sum upd_delta over each replica sweep, SHALL be output as snap_energy alongside the snapshot, and SHALL clear after the handshake.
REQ-032 Without POTTS_ENERGY_TRACK_EN, the snap_energy port and the accumulator SHALL be absent.

Structure
REQ-033 A shared package potts_pkg SHALL hold the FSM state enum, the clog2 helper and the 16-bit sweep-count width constant.
REQ-034 The sub-module potts_state_bank SHALL hold the replica registers, one write port and two read ports (cur_state, snap_data).

Verification
REQ-035 Defaults, num_sweeps=1, sampler returns upd_bit=1 after 2 cycles -> 2 snapshots, each of data 0xFF, snap_rep 0 then 1, then done; mem_req count 16.
REQ-036 snap_ready held low 10 cycles in SNAP -> snap_* stable, no mem_req, progress resumes after handshake.
REQ-037 num_sweeps=0 -> done exactly 1 cycle after start, busy high 1 cycle.
REQ-038 rst asserted in WAIT, then upd_valid pulsed -> states all 0, IDLE, no commit.
REQ-039 POTTS_ENERGY_TRACK_EN defined, upd_delta=-1 on every update -> snap_energy=-8 on each snapshot.
REQ-040 start pulsed while busy -> no effect on counters or snap_sweep sequence.
